tcam_req_arbiter: RTL and testbench

TCAM_REQ_ARBITER -- requirements
Module: tcam_req_arbiter

---
 rtl/tcam_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tcam_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ packet dispatchers share a single TCAM lookup port.
// Define TCAM_ARB_TIMEOUT_EN to answer a lost TCAM response with a null result after TIMEOUT_CYCLES.
module tcam_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 192,
  parameter int DEST_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         end_init_tcam,
  input  logic [NUM_REQ-1:0]           s_req_valid,
  output logic [NUM_REQ-1:0]           s_req_ready,
  input  logic [NUM_REQ*KEY_WIDTH-1:0] s_req_key,
  output logic                         m_tcam_req_valid,
  input  logic                         m_tcam_req_ready,
  output logic [KEY_WIDTH-1:0]         m_tcam_req_key,
  input  logic                         tcam_res_valid,
  input  logic                         tcam_res_null,
  input  logic [DEST_WIDTH-1:0]        tcam_res_data,
  output logic [NUM_REQ-1:0]           s_res_valid,
  output logic                         s_res_null,
  output logic [DEST_WIDTH-1:0]        s_res_data,
  output logic [GW-1:0]                grant_id,
  output logic                         busy,
  output logic [31:0]                  timeout_count
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tcam_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES
  } state_e;

  state_e                  state_q, state_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [KEY_WIDTH-1:0]    key_q, key_d;
  logic [NUM_REQ-1:0]      res_valid_q, res_valid_d;
  logic                    res_null_q, res_null_d;
  logic [DEST_WIDTH-1:0]   res_data_q, res_data_d;

  logic                    win_found;
  logic [GW-1:0]           win_idx;
  logic [GW-1:0]           cand;
  logic                    timeout_fire;

  // Search starts one past the last served requester, so whoever was just
  // answered has the lowest priority in the very next IDLE cycle.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && s_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef TCAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]   timeout_count_q, timeout_count_d;

  always_comb begin
    tmo_cnt_d       = '0;
    timeout_count_d = timeout_count_q;
    timeout_fire    = 1'b0;
    if (state_q == ST_WAIT_RES && !tcam_res_valid) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_fire = 1'b1;
        if (timeout_count_q != 32'hFFFF_FFFF) timeout_count_d = timeout_count_q + 32'd1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q       <= '0;
      timeout_count_q <= '0;
    end else begin
      tmo_cnt_q       <= tmo_cnt_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign timeout_count = timeout_count_q;
`else
  assign timeout_fire  = 1'b0;
  assign timeout_count = 32'd0;
`endif

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d          = state_q;
    grant_id_d       = grant_id_q;
    last_grant_d     = last_grant_q;
    key_d            = key_q;
    res_valid_d      = '0;
    res_null_d       = 1'b0;
    res_data_d       = '0;
    s_req_ready      = '0;
    m_tcam_req_valid = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        if (end_init_tcam) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (win_found) begin
          s_req_ready[win_idx] = 1'b1;
          grant_id_d           = win_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) key_d = s_req_key[i*KEY_WIDTH +: KEY_WIDTH];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_tcam_req_valid = 1'b1;
        if (m_tcam_req_ready) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        // A null result always carries zero data, whether real or timed out.
        if (tcam_res_valid) begin
          res_valid_d[grant_id_q] = 1'b1;
          res_null_d              = tcam_res_null;
          res_data_d              = tcam_res_null ? '0 : tcam_res_data;
          last_grant_d            = grant_id_q;
          state_d                 = ST_IDLE;
        end else if (timeout_fire) begin
          res_valid_d[grant_id_q] = 1'b1;
          res_null_d              = 1'b1;
          last_grant_d            = grant_id_q;
          state_d                 = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      key_q        <= '0;
      res_valid_q  <= '0;
      res_null_q   <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      key_q        <= key_d;
      res_valid_q  <= res_valid_d;
      res_null_q   <= res_null_d;
      res_data_q   <= res_data_d;
    end
  end

  assign m_tcam_req_key = key_q;
  assign s_res_valid    = res_valid_q;
  assign s_res_null     = res_null_q;
  assign s_res_data     = res_data_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RES);

endmodule

// File: tb/tb_tcam_req_arbiter.sv
// Scoreboard bench for tcam_req_arbiter: directed lookups push expected grants and
// responses into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_tcam_req_arbiter;

  localparam int NR = 4;
  localparam int KW = 192;
  localparam int DW = 3;

  typedef struct packed {
    logic [NR-1:0] v;
    logic          n;
    logic [DW-1:0] d;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             end_init_tcam;
  logic [NR-1:0]    s_req_valid;
  logic [NR-1:0]    s_req_ready;
  logic [NR*KW-1:0] s_req_key;
  logic             m_tcam_req_valid;
  logic             m_tcam_req_ready;
  logic [KW-1:0]    m_tcam_req_key;
  logic             tcam_res_valid;
  logic             tcam_res_null;
  logic [DW-1:0]    tcam_res_data;
  logic [NR-1:0]    s_res_valid;
  logic             s_res_null;
  logic [DW-1:0]    s_res_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic [31:0]      timeout_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_grant[$];
  res_t exp_res[$];

  tcam_req_arbiter #(
    .NUM_REQ(NR), .KEY_WIDTH(KW), .DEST_WIDTH(DW), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .end_init_tcam(end_init_tcam),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_key(s_req_key),
    .m_tcam_req_valid(m_tcam_req_valid), .m_tcam_req_ready(m_tcam_req_ready),
    .m_tcam_req_key(m_tcam_req_key),
    .tcam_res_valid(tcam_res_valid), .tcam_res_null(tcam_res_null), .tcam_res_data(tcam_res_data),
    .s_res_valid(s_res_valid), .s_res_null(s_res_null), .s_res_data(s_res_data),
    .grant_id(grant_id), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [KW-1:0] key_of(input int i);
    logic [KW-1:0] k;
    k             = '0;
    k[31:0]       = 32'h1234_0000 + i;
    k[95:64]      = 32'h5A5A_0000 ^ i;
    k[KW-1 -: 32] = 32'hCAFE_0000 + i;
    return k;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: grants and responses are compared only when the DUT presents them.
  always @(negedge clk) begin
    if (s_req_ready != '0) begin
      if (exp_grant.size() == 0) check("unexpected_grant", s_req_ready, '0);
      else check("grant_onehot", s_req_ready, onehot(exp_grant.pop_front()));
    end
    if (s_res_valid != '0) begin
      if (exp_res.size() == 0) check("unexpected_resp", s_res_valid, '0);
      else check("resp", {s_res_valid, s_res_null, s_res_data}, exp_res.pop_front());
    end else begin
      check("resp_idle_zero", {s_res_null, s_res_data}, '0);
    end
  end

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_tcam_req_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Runs one full lookup for requester id; returns in the response cycle.
  task automatic lookup(input int id, input int rdy_wait, input int res_wait,
                        input bit nul, input logic [DW-1:0] data);
    bit   ok;
    res_t r;
    exp_grant.push_back(id);
    r.v = onehot(id);
    r.n = nul;
    r.d = nul ? '0 : data;
    exp_res.push_back(r);
    wait_issue(ok);
    if (!ok) begin
      check("issue_wait", m_tcam_req_valid, 1'b1);
      return;
    end
    check("grant_id", grant_id, id);
    check("req_key", m_tcam_req_key, key_of(id));
    for (int i = 0; i < rdy_wait; i++) begin
      check("stall_valid", m_tcam_req_valid, 1'b1);
      check("stall_key", m_tcam_req_key, key_of(id));
      tick();
    end
    m_tcam_req_ready = 1'b1;
    tick();
    m_tcam_req_ready = 1'b0;
    check("single_transfer", m_tcam_req_valid, 1'b0);
    check("busy_wait_res", busy, 1'b1);
    repeat (res_wait) tick();
    tcam_res_valid = 1'b1;
    tcam_res_null  = nul;
    tcam_res_data  = data;
    tick();
    tcam_res_valid = 1'b0;
    tcam_res_null  = 1'b0;
    tcam_res_data  = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n            = 1'b0;
    end_init_tcam    = 1'b0;
    s_req_valid      = '0;
    m_tcam_req_ready = 1'b0;
    tcam_res_valid   = 1'b0;
    tcam_res_null    = 1'b0;
    tcam_res_data    = '0;
    for (int i = 0; i < NR; i++) s_req_key[i*KW +: KW] = key_of(i);
    tick();
    tick();

    check("rst_ready", s_req_ready, '0);
    check("rst_tcam_valid", m_tcam_req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_res_valid", s_res_valid, '0);

    // Requests wait in INIT until the table is ready.
    rst_n       = 1'b1;
    s_req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      check("init_ready_low", s_req_ready, '0);
      tick();
    end
    end_init_tcam = 1'b1;
    lookup(0, 0, 0, 1'b0, 3'd1);
    s_req_valid = '0;

`ifdef TCAM_ARB_TIMEOUT_EN
    begin
      res_t r;
      s_req_valid = 4'b1000;
      exp_grant.push_back(3);
      r.v = 4'b1000;
      r.n = 1'b1;
      r.d = '0;
      exp_res.push_back(r);
      wait_issue(ok);
      if (!ok) check("tmo_issue_wait", m_tcam_req_valid, 1'b1);
      s_req_valid      = '0;
      m_tcam_req_ready = 1'b1;
      tick();
      m_tcam_req_ready = 1'b0;
      repeat (63) tick();
      check("tmo_not_early", s_res_valid, '0);
      tick();
      check("tmo_fire", s_res_valid, 4'b1000);
      check("tmo_count", timeout_count, 1);
      tick();
      tcam_res_valid = 1'b1;
      tcam_res_data  = 3'd6;
      tick();
      tcam_res_valid = 1'b0;
      tcam_res_data  = '0;
      tick();
      check("tmo_count_after_late", timeout_count, 1);
    end
`else
    s_req_valid = 4'b1000;
    lookup(3, 0, 80, 1'b0, 3'd2);
    s_req_valid = '0;
    check("no_timeout_count", timeout_count, 0);
`endif

    // All requesters streaming back to back.
    s_req_valid = 4'b1111;
    lookup(0, 0, 0, 1'b0, 3'd5);
    lookup(1, 0, 0, 1'b0, 3'd5);
    lookup(2, 0, 0, 1'b0, 3'd5);
    lookup(3, 0, 0, 1'b0, 3'd5);
    lookup(0, 0, 0, 1'b0, 3'd5);
    s_req_valid = '0;

    // TCAM back-pressure for 7 cycles.
    s_req_valid = 4'b0010;
    lookup(1, 7, 2, 1'b0, 3'd3);
    s_req_valid = '0;

    // Null result: data must read as zero even though the TCAM drives garbage.
    s_req_valid = 4'b0100;
    lookup(2, 0, 1, 1'b1, 3'd6);
    s_req_valid = '0;

    // Requester 2 re-asserts right after its response and must wait behind 1.
    s_req_valid = 4'b0110;
    lookup(1, 0, 0, 1'b0, 3'd4);
    lookup(2, 0, 0, 1'b0, 3'd7);
    s_req_valid = '0;

    // Reset mid-lookup: in-flight request is dropped and priority restarts at 0.
    s_req_valid = 4'b0010;
    lookup(1, 0, 0, 1'b0, 3'd1);
    s_req_valid = 4'b0100;
    exp_grant.push_back(2);
    wait_issue(ok);
    if (!ok) check("rst_issue_wait", m_tcam_req_valid, 1'b1);
    s_req_valid      = '0;
    m_tcam_req_ready = 1'b1;
    tick();
    m_tcam_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_res_valid", s_res_valid, '0);
    check("midrst_tcam_valid", m_tcam_req_valid, 1'b0);
    tcam_res_valid = 1'b1;
    tcam_res_data  = 3'd3;
    tick();
    tcam_res_valid = 1'b0;
    tcam_res_data  = '0;
    s_req_valid    = 4'b0111;
    lookup(0, 0, 0, 1'b0, 3'd2);
    s_req_valid = '0;

    repeat (4) tick();
    check("grant_queue_empty", exp_grant.size(), 0);
    check("resp_queue_empty", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
